// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: edge-detects peripheral request lines, latches them as
// pending, and runs a req/ack/done handshake with the CPU, one request at a time.
module interrupt_controller #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_data,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vector,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_d;
  logic             int_req_q, int_req_d;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic             in_service_q, in_service_d;

  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] clear;
  logic [N_IRQ-1:0] eligible;
  logic [VEC_W-1:0] winner;

  assign irq_edge = irq_in & ~prev_q;
  assign eligible = pending_q & mask_q;

  // Lowest index wins: scanning downward lets the last hit overwrite earlier ones.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = VEC_W'(i);
      end
    end
  end

  always_comb begin
    clear = '0;
    if (state_q == REQ && int_ack) begin
      clear[vector_q] = 1'b1;
    end
  end

  // A fresh edge in the acknowledge cycle keeps the bit pending.
  assign pending_d = irq_edge | (pending_q & ~clear);
  assign mask_d    = mask_we ? mask_data : mask_q;

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    unique case (state_q)
      IDLE: begin
        in_service_d = 1'b0;
        if (eligible != '0) begin
          vector_d  = winner;
          int_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      int_req_q    <= 1'b0;
      vector_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_req_q    <= int_req_d;
      vector_q     <= vector_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_vector = vector_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed-vector bench for interrupt_controller: each row drives one cycle of inputs and
// gives the outputs expected just after that clock edge.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irqIn;
  logic       maskWe;
  logic [7:0] maskData;
  logic       intAck;
  logic       intDone;
  logic       intReq;
  logic [2:0] intVector;
  logic       inService;
  logic [7:0] pendingOut;
  logic [7:0] maskOut;

  int nApplied    = 0;
  int nMiscompares = 0;

  typedef struct {
    logic       rst;
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] mdata;
    logic       ack;
    logic       done;
    logic       eReq;
    logic [2:0] eVec;
    logic       eSvc;
    logic [7:0] ePend;
    logic [7:0] eMask;
  } vec_t;

  vec_t vecs[$];

  interrupt_controller #(.N_IRQ(8), .VEC_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irqIn),
    .mask_we    (maskWe),
    .mask_data  (maskData),
    .int_ack    (intAck),
    .int_done   (intDone),
    .int_req    (intReq),
    .int_vector (intVector),
    .in_service (inService),
    .pending    (pendingOut),
    .mask_q     (maskOut)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [7:0] irq, logic mwe, logic [7:0] mdata,
                              logic ack, logic done, logic eReq, logic [2:0] eVec,
                              logic eSvc, logic [7:0] ePend, logic [7:0] eMask);
    vec_t v;
    v.rst = rst; v.irq = irq; v.mwe = mwe; v.mdata = mdata; v.ack = ack; v.done = done;
    v.eReq = eReq; v.eVec = eVec; v.eSvc = eSvc; v.ePend = ePend; v.eMask = eMask;
    return v;
  endfunction

  // Drive one cycle of inputs, then let the edge happen and settle.
  task automatic applyStimulus(input logic rst, input logic [7:0] irq, input logic mwe,
                               input logic [7:0] mdata, input logic ack, input logic done);
    reset    = rst;
    irqIn    = irq;
    maskWe   = mwe;
    maskData = mdata;
    intAck   = ack;
    intDone  = done;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eReq, input logic [2:0] eVec,
                             input logic eSvc, input logic [7:0] ePend, input logic [7:0] eMask);
    nApplied++;
    if ({intReq, intVector, inService, pendingOut, maskOut} !== {eReq, eVec, eSvc, ePend, eMask}) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got req=%b vec=%0d svc=%b pend=%h mask=%h, want req=%b vec=%0d svc=%b pend=%h mask=%h",
               name, intReq, intVector, inService, pendingOut, maskOut, eReq, eVec, eSvc, ePend, eMask);
    end
  endtask

  initial begin
    bit gotReq;

    // Reset, single pulse on line 2, full handshake, ack/done ignored in IDLE
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h04, 0, 8'h00, 0, 0, 0, 0, 0, 8'h04, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 2, 0, 8'h04, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 2, 1, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 2, 1, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 2, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 2, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 2, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 2, 0, 8'h00, 8'hFF));
    // Simultaneous edges on lines 5 and 1; done in REQ and ack in SERVICE ignored
    vecs.push_back(mk(0, 8'h22, 0, 8'h00, 0, 0, 0, 2, 0, 8'h22, 8'hFF));
    vecs.push_back(mk(0, 8'h22, 0, 8'h00, 0, 0, 1, 1, 0, 8'h22, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 0, 8'h22, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h20, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h20, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 8'h20, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 5, 0, 8'h20, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 5, 1, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 5, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 5, 0, 8'h00, 8'hFF));
    // Masked line latches but is not requested until unmasked
    vecs.push_back(mk(0, 8'h00, 1, 8'hFE, 0, 0, 0, 5, 0, 8'h00, 8'hFE));
    vecs.push_back(mk(0, 8'h01, 0, 8'h00, 0, 0, 0, 5, 0, 8'h01, 8'hFE));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 5, 0, 8'h01, 8'hFE));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 5, 0, 8'h01, 8'hFE));
    vecs.push_back(mk(0, 8'h00, 1, 8'hFF, 0, 0, 0, 5, 0, 8'h01, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h01, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'hFF));
    // Vector 3 held in REQ for 20 cycles; line 0 arrives and mask changes, vector frozen
    vecs.push_back(mk(0, 8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 8'h08, 8'hFF));
    vecs.push_back(mk(0, 8'h08, 0, 8'h00, 0, 0, 1, 3, 0, 8'h08, 8'hFF));
    for (int k = 0; k < 20; k++) begin
      vecs.push_back(mk(0, (k >= 5) ? 8'h09 : 8'h08, (k == 10 || k == 12),
                        (k == 10) ? 8'hF7 : 8'hFF, 0, 0, 1, 3, 0,
                        (k >= 5) ? 8'h09 : 8'h08, (k >= 10 && k < 12) ? 8'hF7 : 8'hFF));
    end
    vecs.push_back(mk(0, 8'h09, 0, 8'h00, 1, 0, 0, 3, 1, 8'h01, 8'hFF));
    vecs.push_back(mk(0, 8'h09, 0, 8'h00, 0, 1, 0, 3, 0, 8'h01, 8'hFF));
    vecs.push_back(mk(0, 8'h09, 0, 8'h00, 0, 0, 1, 0, 0, 8'h01, 8'hFF));
    vecs.push_back(mk(0, 8'h09, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h09, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));
    // New edge on line 4 in its own ack cycle keeps it pending; ack+done together
    vecs.push_back(mk(0, 8'h10, 0, 8'h00, 0, 0, 0, 0, 0, 8'h10, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 4, 0, 8'h10, 8'hFF));
    vecs.push_back(mk(0, 8'h10, 0, 8'h00, 1, 1, 0, 4, 1, 8'h10, 8'hFF));
    vecs.push_back(mk(0, 8'h10, 0, 8'h00, 0, 1, 0, 4, 0, 8'h10, 8'hFF));
    vecs.push_back(mk(0, 8'h10, 0, 8'h00, 0, 0, 1, 4, 0, 8'h10, 8'hFF));
    vecs.push_back(mk(0, 8'h10, 0, 8'h00, 1, 1, 0, 4, 1, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h10, 0, 8'h00, 0, 1, 0, 4, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 4, 0, 8'h00, 8'hFF));
    // Reset during SERVICE with pending 8'h12 and a non-default mask
    vecs.push_back(mk(0, 8'h12, 0, 8'h00, 0, 0, 0, 4, 0, 8'h12, 8'hFF));
    vecs.push_back(mk(0, 8'h12, 0, 8'h00, 0, 0, 1, 1, 0, 8'h12, 8'hFF));
    vecs.push_back(mk(0, 8'h12, 0, 8'h00, 1, 0, 0, 1, 1, 8'h10, 8'hFF));
    vecs.push_back(mk(0, 8'h10, 0, 8'h00, 0, 0, 0, 1, 1, 8'h10, 8'hFF));
    vecs.push_back(mk(0, 8'h12, 0, 8'h00, 0, 0, 0, 1, 1, 8'h12, 8'hFF));
    vecs.push_back(mk(0, 8'h12, 1, 8'h0F, 0, 0, 0, 1, 1, 8'h12, 8'h0F));
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));
    // Line held high through reset release registers exactly one request
    vecs.push_back(mk(1, 8'h01, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h01, 0, 8'h00, 0, 0, 0, 0, 0, 8'h01, 8'hFF));
    vecs.push_back(mk(0, 8'h01, 0, 8'h00, 0, 0, 1, 0, 0, 8'h01, 8'hFF));
    vecs.push_back(mk(0, 8'h01, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h01, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h01, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].irq, vecs[i].mwe, vecs[i].mdata, vecs[i].ack, vecs[i].done);
      checkOutput($sformatf("row %0d", i), vecs[i].eReq, vecs[i].eVec, vecs[i].eSvc,
                  vecs[i].ePend, vecs[i].eMask);
    end

    // Single pulse on line 6, waiting a bounded number of cycles for the request
    applyStimulus(0, 8'h40, 0, 8'h00, 0, 0);
    checkOutput("line6 pending", 0, 0, 0, 8'h40, 8'hFF);
    gotReq = 0;
    for (int c = 0; c < 8 && !gotReq; c++) begin
      applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);
      gotReq = intReq;
    end
    nApplied++;
    if (!gotReq || intVector !== 3'd6) begin
      nMiscompares++;
      $display("[TB] FAIL line6 request: got req=%b vec=%0d, want req=1 vec=6", gotReq, intVector);
    end
    applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
    checkOutput("line6 ack", 0, 6, 1, 8'h00, 8'hFF);
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 1);
    checkOutput("line6 done", 0, 6, 0, 8'h00, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
